// File: rtl/maint_scheduler.sv
// Shared-technician maintenance scheduler.
// Round-robin grant over explicit requests and interval-overdue machines.
module maint_scheduler #(
  parameter int N_MACH         = 4,
  parameter int SERVICE_CYCLES = 8,
  parameter int INTERVAL       = 100,
  localparam int IW  = $clog2(INTERVAL + 1),
  localparam int IDW = $clog2(N_MACH),
  localparam int SW  = (SERVICE_CYCLES > 1) ?
                       $clog2(SERVICE_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_MACH-1:0] req,
  output logic [N_MACH-1:0] grant,
  output logic [IDW-1:0]    svc_id,
  output logic              busy,
  output logic              forced,
  output logic              done,
  output logic [N_MACH-1:0] due,
  output logic [7:0]        total
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [SW-1:0]     svc_cnt;
  logic [IDW-1:0]    rr_ptr;
  logic [IW-1:0]     cnt [N_MACH];
  logic [N_MACH-1:0] pend;
  logic [IDW-1:0]    win;
  logic              hit;
  logic              last;

  // Overdue flags and the combined pending vector
  always_comb begin
    due  = '0;
    pend = '0;
    for (int i = 0; i < N_MACH; i++) begin
      due[i]  = (cnt[i] == IW'(INTERVAL));
      pend[i] = req[i] | due[i];
    end
  end

  // Round-robin pick: first pending index from rr_ptr upward, wrapping
  always_comb begin
    int j;
    win = '0;
    hit = |pend;
    j   = 0;
    for (int k = N_MACH - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_MACH) j = j - N_MACH;
      if (pend[j]) win = IDW'(j);
    end
  end

  assign last = (svc_cnt == SW'(SERVICE_CYCLES - 1));

  // Next-state logic and decoded outputs
  always_comb begin
    state_n = state;
    grant   = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) state_n = SERVICE;
      end
      SERVICE: begin
        busy = 1'b1;
        for (int i = 0; i < N_MACH; i++)
          grant[i] = (svc_id == IDW'(i));
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Selection, service timer, pointer and total bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      svc_id  <= '0;
      forced  <= 1'b0;
      svc_cnt <= '0;
      rr_ptr  <= '0;
      total   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            svc_id  <= win;
            forced  <= ~req[win];
            svc_cnt <= '0;
          end
        end
        SERVICE: begin
          if (!last) svc_cnt <= svc_cnt + 1'b1;
        end
        DONE: begin
          forced <= 1'b0;
          if (total != 8'hff) total <= total + 8'd1;
          if (svc_id == IDW'(N_MACH - 1)) rr_ptr <= '0;
          else rr_ptr <= svc_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Interval counters: saturate at INTERVAL, cleared when served
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MACH; i++) begin
      if (!rst)
        cnt[i] <= '0;
      else if (state == DONE && svc_id == IDW'(i))
        cnt[i] <= '0;
      else if (cnt[i] != IW'(INTERVAL))
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed bench for maint_scheduler (N_MACH=4, 8-cycle service,
// interval 100).
module tb_maint_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic [1:0] svc_id;
  logic       busy;
  logic       forced;
  logic       done;
  logic [3:0] due;
  logic [7:0] total;

  int tests = 0;
  int fails = 0;

  maint_scheduler #(
    .N_MACH(4),
    .SERVICE_CYCLES(8),
    .INTERVAL(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant(grant),
    .svc_id(svc_id),
    .busy(busy),
    .forced(forced),
    .done(done),
    .due(due),
    .total(total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic       forced;
    logic [1:0] id;
    logic [7:0] total;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    int bad;
    int n;
    int dn;
    logic [3:0] eg;
    logic [31:0] a, e;

    // pulse req[2] from reset, then req=1111 resumes at rr_ptr=3
    for (int i = 0; i < 12; i++)
      tbl[i] = '{4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0};
    tbl[0].req = 4'b0100;
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1};
    tbl[10] = '{4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1};
    tbl[11] = '{4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1};

    // reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_forced", 32'(forced), 32'h0);
    chk("rst_total", 32'(total), 32'h0);
    chk("rst_id", 32'(svc_id), 32'h0);
    chk("rst_due", 32'(due), 32'h0);

    // idle run to interval expiry
    bad = 0;
    for (int c = 1; c <= 99; c++) begin
      step();
      if (grant != 4'b0) bad++;
    end
    chk("idle_grant_cycles", 32'(bad), 32'h0);
    chk("idle99_due", 32'(due), 32'h0);
    chk("idle99_total", 32'(total), 32'h0);
    step();
    chk("idle100_due", 32'(due), 32'hf);
    chk("idle100_grant", 32'(grant), 32'h0);
    step();
    chk("due_grant", 32'(grant), 32'h1);
    chk("due_forced", 32'(forced), 32'h1);
    chk("due_id", 32'(svc_id), 32'h0);

    // table vectors
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      step();
      a = {grant, 3'b0, busy, 3'b0, done,
           3'b0, forced, 2'b0, svc_id, total};
      e = {tbl[i].grant, 3'b0, tbl[i].busy, 3'b0, tbl[i].done,
           3'b0, tbl[i].forced, 2'b0, tbl[i].id, tbl[i].total};
      chk($sformatf("vec%0d", i), a, e);
    end

    // round robin with all requests held
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      eg = 4'b0001 << (s % 4);
      n = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (grant == eg && busy) n++;
      end
      chk($sformatf("rr%0d_len", s), 32'(n), 32'd8);
      step();
      chk($sformatf("rr%0d_done", s), {grant, 3'b0, done}, 32'h1);
      step();
      chk($sformatf("rr%0d_gap", s), 32'(grant), 32'h0);
      chk($sformatf("rr%0d_total", s), 32'(total), 32'(s + 1));
    end

    // request dropped mid-service, another rises
    do_reset();
    req = 4'b0010;
    step();
    step();
    step();
    req = 4'b0001;
    n = 3;
    for (int c = 0; c < 5; c++) begin
      step();
      if (grant == 4'b0010) n++;
    end
    chk("drop_len", 32'(n), 32'd8);
    step();
    chk("drop_done", 32'(done), 32'h1);
    step();
    step();
    chk("drop_next_grant", 32'(grant), 32'h1);
    chk("drop_next_id", 32'(svc_id), 32'h0);

    // saturate total
    do_reset();
    req = 4'b1111;
    n = 0;
    while (total != 8'hff && n < 3000) begin
      step();
      n++;
    end
    chk("sat_reached", 32'(total), 32'hff);
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done) dn++;
    end
    chk("sat_dones", 32'(dn >= 2), 32'h1);
    chk("sat_hold", 32'(total), 32'hff);

    // reset in the middle of a service
    n = 0;
    while (!busy && n < 12) begin
      step();
      n++;
    end
    chk("mid_busy", 32'(busy), 32'h1);
    step();
    step();
    step();
    rst = 1'b0;
    req = 4'b0;
    step();
    chk("mid_grant", 32'(grant), 32'h0);
    chk("mid_busy0", 32'(busy), 32'h0);
    chk("mid_total", 32'(total), 32'h0);
    chk("mid_due", 32'(due), 32'h0);
    chk("mid_done", 32'(done), 32'h0);
    rst = 1'b1;
    req = 4'b0001;
    step();
    chk("post_grant", 32'(grant), 32'h1);
    chk("post_forced", 32'(forced), 32'h0);
    chk("post_id", 32'(svc_id), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maint_scheduler.md
Name: maint_scheduler

Overview:
Shares a single maintenance technician among N_MACH machines. Each machine can request maintenance explicitly. Each machine also has its own interval counter that forces a request once INTERVAL cycles pass without service. A round-robin arbiter grants one machine at a time, holds the grant for SERVICE_CYCLES, and counts completed services in an 8-bit total that feeds the existing total/display path.

Parameters:
N_MACH, 4, number of machines sharing the technician (2..8)
SERVICE_CYCLES, 8, cycles the grant is held per service (>=1)
INTERVAL, 100, cycles since last service after which a machine becomes due (>=1)
IW, $clog2(INTERVAL+1), interval counter width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset (rst=0 resets on the next rising edge)
req  in  N_MACH  level maintenance request per machine
grant  out  N_MACH  one-hot grant; all zero when no service is in progress
svc_id  out  $clog2(N_MACH)  index of machine currently or last served
busy  out  1  high while in SERVICE
forced  out  1  high during a service whose selection was due-only (req bit low at selection)
done  out  1  one-cycle pulse in the DONE state
due  out  N_MACH  per-machine overdue flag (interval counter == INTERVAL)
total  out  8  completed-service count, saturating at 255

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, grant=0, svc_id=0, busy=0, forced=0, done=0, total=0, rr_ptr=0.
  - All interval counters = 0; therefore due=0.
  - Reset has priority over everything, including mid-service; an in-progress service is dropped and not counted.
- Interval counters:
  - Each counter increments every cycle and saturates at INTERVAL.
  - due[i] is combinational from counter i == INTERVAL.
  - Counter i is cleared to 0 in the DONE cycle for i == svc_id. If clear and increment coincide, clear wins.
- pending[i] = req[i] | due[i].
- Arbitration: evaluated only in IDLE. The winner is the first pending index scanning rr_ptr, rr_ptr+1, ... modulo N_MACH.
- FSM states and transitions:
  - IDLE: if any pending, then on the next edge:
    - svc_id <= winner;
    - forced <= ~req[winner];
    - svc_cnt <= 0;
    - go to SERVICE.
    Otherwise stay in IDLE.
  - SERVICE:
    - grant = one-hot(svc_id) and busy = 1.
    - svc_cnt increments each cycle.
    - When svc_cnt == SERVICE_CYCLES-1, go to DONE.
    - Grant is therefore high for exactly SERVICE_CYCLES cycles.
  - DONE (1 cycle):
    - grant = 0, busy = 0, done = 1.
    - total <= total+1 unless total == 255.
    - Counter[svc_id] is cleared.
    - rr_ptr <= (svc_id+1) mod N_MACH.
    - forced is cleared on exit.
    - Next state is IDLE.
- Timing:
  - Latency from pending in IDLE to first grant cycle: 1 cycle.
  - Back-to-back services have a 2-cycle gap between grants (DONE + IDLE).
- Request changes during SERVICE: ignored. Deasserting req does not abort a service; new requests wait for IDLE.
- svc_id holds the last served index while in IDLE.
- grant is registered with the state (decoded from state+svc_id), so it is glitch-free and never multi-hot.
- total saturates at 255 and does not wrap.
- If N_MACH is not a power of two, rr_ptr wrap is explicit modulo N_MACH and never reaches an unused index.

Test Plan:
- Reset, then req=4'b0000 for 99 cycles -> grant=0, total=0, due=0. At cycle 100 after reset, due=4'b1111 and machine 0 is granted next cycle with forced=1.
- From reset, pulse req=4'b0100 for 1 cycle -> grant=4'b0100 starting 1 cycle later for exactly 8 cycles, busy=1 during those cycles, done pulse after, total=1, svc_id=2, forced=0, rr_ptr=3.
- req=4'b1111 held -> grants in order 0,1,2,3,0. Each grant lasts 8 cycles with 2 idle cycles between grants; total increments once per DONE.
- req=4'b0010 asserted, then dropped at service cycle 3 while req=4'b0001 rises -> machine 1 service completes all 8 cycles, then machine 0 is granted.
- Force total to 255 via long run (or a reduced INTERVAL/SERVICE_CYCLES=1 build) -> further DONE pulses leave total=255.
- Assert rst=0 mid-SERVICE (cycle 4) -> next edge: grant=0, busy=0, total unchanged-to-0 (reset value), counters 0, state IDLE. Releasing reset with req=0001 grants machine 0.
